// File: rtl/rsa_pkg.sv
// rsa_pkg: shared FSM states, default LFSR taps and mask helper for the exponent search
package rsa_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_DIV, S_CHECK, S_DONE} state_t;
  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;
  localparam int MASK_W = 64;
  function automatic logic [MASK_W-1:0] msb_mask(input logic [MASK_W-1:0] x);
    logic [MASK_W-1:0] m;
    m = x;
    for (int i = 1; i < MASK_W; i = i * 2) m = m | (m >> i);
    return m;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one load cycle then one quotient bit per cycle
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic done_q;
  logic [WIDTH:0] trial;
  logic fits;
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign fits = trial >= {1'b0, dvs_q};
  // dividend shifts out of the quotient register into the partial remainder
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q <= '0;
        quo_q <= dividend;
        dvs_q <= divisor;
        cnt_q <= CW'(WIDTH);
      end else if (cnt_q != '0) begin
        rem_q <= fits ? WIDTH'(trial - {1'b0, dvs_q}) : trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], fits};
        cnt_q <= cnt_q - 1'b1;
        done_q <= cnt_q == CW'(1);
      end
    end
  end
  assign done = done_q;
  assign remainder = rem_q;
  assign quotient = quo_q;
endmodule

// File: rtl/coprime_e_search.sv
// coprime_e_search: draws LFSR candidates and keeps the first one coprime to phi
module coprime_e_search import rsa_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int MAX_TRIES = 255,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'(DEFAULT_TAPS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               seed,
  input  logic [WIDTH-1:0]               phi,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [WIDTH-1:0]               e_key,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, phi_q, phi_d, b_q, b_d, e_q, e_d, key_q, key_d;
  logic [TW-1:0] tries_q, tries_d, tries_inc;
  logic err_q, err_d;
  logic [WIDTH-1:0] mask, cand, lfsr_nxt;
  logic div_start, div_done;
  logic [WIDTH-1:0] div_dividend, div_divisor, rem, quo_unused;
  assign mask = WIDTH'(msb_mask(MASK_W'(phi_q)));
  assign cand = (lfsr_q & mask) | WIDTH'(1);
  assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign tries_inc = tries_q + 1'b1;
  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk(clk),
    .rst(rst),
    .start(div_start),
    .dividend(div_dividend),
    .divisor(div_divisor),
    .done(div_done),
    .remainder(rem),
    .quotient(quo_unused)
  );
  // search sequencing: draw, Euclid steps via the divider, accept or redraw
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    phi_d = phi_q;
    b_d = b_q;
    e_d = e_q;
    key_d = key_q;
    tries_d = tries_q;
    err_d = err_q;
    div_start = 1'b0;
    div_dividend = phi_q;
    div_divisor = cand;
    case (state_q)
      S_IDLE: if (start) begin
        phi_d = phi;
        lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        tries_d = '0;
        key_d = '0;
        err_d = phi < WIDTH'(4);
        state_d = (phi < WIDTH'(4)) ? S_DONE : S_DRAW;
      end
      S_DRAW: begin
        lfsr_d = lfsr_nxt;
        tries_d = tries_inc;
        if (cand < WIDTH'(3) || cand >= phi_q) begin
          err_d = tries_inc == TW'(MAX_TRIES);
          state_d = (tries_inc == TW'(MAX_TRIES)) ? S_DONE : S_DRAW;
        end else begin
          b_d = cand;
          e_d = cand;
          div_start = 1'b1;
          state_d = S_DIV;
        end
      end
      S_DIV: state_d = div_done ? S_CHECK : S_DIV;
      S_CHECK: if (rem == WIDTH'(1)) begin
        key_d = e_q;
        state_d = S_DONE;
      end else if (rem == '0) begin
        err_d = tries_q == TW'(MAX_TRIES);
        state_d = (tries_q == TW'(MAX_TRIES)) ? S_DONE : S_DRAW;
      end else begin
        div_dividend = b_q;
        div_divisor = rem;
        b_d = rem;
        div_start = 1'b1;
        state_d = S_DIV;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q <= WIDTH'(1);
      phi_q <= '0;
      b_q <= '0;
      e_q <= '0;
      key_q <= '0;
      tries_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      phi_q <= phi_d;
      b_q <= b_d;
      e_q <= e_d;
      key_q <= key_d;
      tries_q <= tries_d;
      err_q <= err_d;
    end
  end
  assign busy = (state_q == S_DRAW) || (state_q == S_DIV) || (state_q == S_CHECK);
  assign done = state_q == S_DONE;
  assign err = err_q;
  assign e_key = key_q;
  assign tries = tries_q;
endmodule

// File: tb/tb_coprime_e_search.sv
// tb_coprime_e_search: directed and random checks of the exponent search against an arithmetic model
module tb_coprime_e_search;
  localparam int W = 8;
  localparam logic [W-1:0] TAPS = 8'hB8;
  logic clk = 1'b0;
  logic rst, start, start1;
  logic [W-1:0] seed, phi, seed1, phi1, e_key, key1;
  logic busy, done, err, busy1, done1, err1;
  logic [7:0] tries;
  logic [0:0] tries1;
  int vectors = 0;
  int miscompares = 0;
  int last_n;
  always #5 clk = ~clk;
  coprime_e_search #(.WIDTH(W), .MAX_TRIES(255), .LFSR_TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .phi(phi),
    .busy(busy), .done(done), .err(err), .e_key(e_key), .tries(tries)
  );
  coprime_e_search #(.WIDTH(W), .MAX_TRIES(1), .LFSR_TAPS(TAPS)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed(seed1), .phi(phi1),
    .busy(busy1), .done(done1), .err(err1), .e_key(key1), .tries(tries1)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  function automatic void model(input int p, input int s, input int mt,
                                output int e, output int er, output int tr, output int cy);
    int l, m, c, a, b, r;
    bit fin;
    e = 0; er = 0; tr = 0; cy = 0;
    if (p < 4) begin
      er = 1;
      return;
    end
    l = (s == 0) ? 1 : s;
    m = (1 << $clog2(p + 1)) - 1;
    fin = 0;
    while (!fin) begin
      c = (l & m) | 1;
      l = (l >> 1) ^ (((l & 1) != 0) ? int'(TAPS) : 0);
      tr++;
      cy++;
      if (c >= 3 && c < p) begin
        a = p;
        b = c;
        do begin
          cy += W + 2;
          r = a % b;
          a = b;
          b = r;
        end while (r > 1);
        if (r == 1) begin
          e = c;
          fin = 1;
        end
      end
      if (!fin && tr == mt) begin
        er = 1;
        fin = 1;
      end
    end
  endfunction
  task automatic run(input int p, input int s, input int g, input string tag);
    int e, er, tr, cy, n;
    model(p, s, 255, e, er, tr, cy);
    @(negedge clk);
    phi = W'(p);
    seed = W'(s);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'(p >= 4));
    chk({tag, ".tries0"}, 64'(tries), 0);
    n = 0;
    while (!done && n < cy + 40) begin
      if (n == g) begin
        start = 1'b1;
        phi = 8'd3;
        seed = 8'd0;
      end
      @(posedge clk);
      #1 start = 1'b0;
      phi = W'($urandom);
      seed = W'($urandom);
      n++;
    end
    last_n = n;
    chk({tag, ".cycles"}, 64'(n), 64'(cy));
    chk({tag, ".done"}, 64'(done), 1);
    chk({tag, ".key"}, 64'(e_key), 64'(e));
    chk({tag, ".err"}, 64'(err), 64'(er));
    chk({tag, ".tries"}, 64'(tries), 64'(tr));
    if (!err) begin
      chk({tag, ".gcd"}, 64'(gcd(int'(e_key), p)), 1);
      chk({tag, ".range"}, 64'(e_key >= 3 && int'(e_key) < p), 1);
    end
    @(posedge clk);
    #1 chk({tag, ".pulse"}, 64'(done), 0);
  endtask
  initial begin
    int seen, p, s;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    phi = '0;
    seed = '0;
    phi1 = '0;
    seed1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", 64'(busy), 0);
    chk("reset.done", 64'(done), 0);
    chk("reset.err", 64'(err), 0);
    chk("reset.key", 64'(e_key), 0);
    chk("reset.tries", 64'(tries), 0);
    @(negedge clk);
    rst = 1'b0;
    run(10, 7, -1, "p10s7");
    chk("p10s7.key_c", 64'(e_key), 7);
    chk("p10s7.n_c", 64'(last_n), 21);
    run(4, 3, -1, "p4s3");
    chk("p4s3.key_c", 64'(e_key), 3);
    run(3, 5, -1, "p3");
    chk("p3.err_c", 64'(err), 1);
    chk("p3.n_c", 64'(last_n), 0);
    @(negedge clk);
    phi1 = 8'd6;
    seed1 = 8'd3;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    seen = 0;
    while (!done1 && seen < 60) begin
      @(posedge clk);
      #1 seen++;
    end
    chk("mt1.done", 64'(done1), 1);
    chk("mt1.err", 64'(err1), 1);
    chk("mt1.key", 64'(key1), 0);
    chk("mt1.tries", 64'(tries1), 1);
    run(6, 3, -1, "p6s3");
    chk("p6s3.key_c", 64'(e_key), 5);
    run(10, 0, -1, "seed0");
    chk("seed0.key_c", 64'(e_key), 9);
    chk("seed0.tries_c", 64'(tries), 2);
    run(10, 7, 5, "glitch");
    chk("glitch.key_c", 64'(e_key), 7);
    @(negedge clk);
    phi = 8'd200;
    seed = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rstdiv.busy_pre", 64'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstdiv.busy", 64'(busy), 0);
    chk("rstdiv.done", 64'(done), 0);
    chk("rstdiv.err", 64'(err), 0);
    chk("rstdiv.key", 64'(e_key), 0);
    chk("rstdiv.tries", 64'(tries), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("rstdiv.nodone", 64'(seen), 0);
    for (int i = 0; i < 1000; i++) begin
      p = int'($urandom_range(255, 4));
      s = int'($urandom_range(255, 0));
      run(p, s, ((i % 7) == 0) ? int'($urandom_range(3, 0)) : -1, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
